// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALU codes, main-op classes,
// funct values and control-bundle bit positions.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] MAIN_ADD   = 2'b00;
  localparam logic [1:0] MAIN_SUB   = 2'b01;
  localparam logic [1:0] MAIN_RTYPE = 2'b10;
  localparam logic [1:0] MAIN_OR    = 2'b11;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;

  // IdCtrl = {RegDst, AluSrc, RegWrite, MemRead, MemWrite, MemToReg}
  localparam int C_REGDST = 5;
  localparam int C_ALUSRC = 4;
  // ExCtrl = {RegWrite, MemRead, MemWrite, MemToReg}
  localparam int X_MEMREAD = 2;

  // Main-class / funct to ALU operation
  function automatic logic [2:0] alu_decode(input logic [1:0] main, input logic [5:0] funct);
    logic [2:0] op;
    op = ALU_ADD;
    case (main)
      MAIN_ADD: op = ALU_ADD;
      MAIN_SUB: op = ALU_SUB;
      MAIN_OR:  op = ALU_OR;
      default: begin
        case (funct)
          F_ADD, F_ADDU: op = ALU_ADD;
          F_SUB, F_SUBU: op = ALU_SUB;
          F_AND:         op = ALU_AND;
          F_OR:          op = ALU_OR;
          F_SLT:         op = ALU_SLT;
          F_SLL:         op = ALU_SLL;
          default:       op = ALU_ADD;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID-side inputs, forwarding buses and EX-side outputs of the ID/EX stage.
interface id_ex_operand_stage_if #(parameter int DW = 32, parameter int RW = 5);
  logic            IdValid;
  logic [3*RW-1:0] IdRegs;
  logic [DW-1:0]   IdRsData;
  logic [DW-1:0]   IdRtData;
  logic [DW-1:0]   IdImm;
  logic [10:0]     IdInstrLow;
  logic [1:0]      IdAluOpMain;
  logic [5:0]      IdCtrl;
  logic            IdUsesRt;
  logic            Hold;
  logic            Flush;
  logic            ExMemRegWrite;
  logic [RW-1:0]   ExMemRd;
  logic [DW-1:0]   ExMemResult;
  logic            MemWbRegWrite;
  logic [RW-1:0]   MemWbRd;
  logic [DW-1:0]   MemWbData;
  logic [DW-1:0]   AluInput1;
  logic [DW-1:0]   AluInput2;
  logic [2:0]      AluOP;
  logic [4:0]      ShiftAmount;
  logic            ExValid;
  logic [RW-1:0]   ExWriteReg;
  logic [3:0]      ExCtrl;
  logic [DW-1:0]   ExStoreData;
  logic            HazardStall;

  modport master (
    output IdValid, IdRegs, IdRsData, IdRtData, IdImm, IdInstrLow, IdAluOpMain,
           IdCtrl, IdUsesRt, Hold, Flush, ExMemRegWrite, ExMemRd, ExMemResult,
           MemWbRegWrite, MemWbRd, MemWbData,
    input  AluInput1, AluInput2, AluOP, ShiftAmount, ExValid, ExWriteReg,
           ExCtrl, ExStoreData, HazardStall
  );

  modport slave (
    input  IdValid, IdRegs, IdRsData, IdRtData, IdImm, IdInstrLow, IdAluOpMain,
           IdCtrl, IdUsesRt, Hold, Flush, ExMemRegWrite, ExMemRd, ExMemResult,
           MemWbRegWrite, MemWbRd, MemWbData,
    output AluInput1, AluInput2, AluOP, ShiftAmount, ExValid, ExWriteReg,
           ExCtrl, ExStoreData, HazardStall
  );
endinterface

// File: rtl/id_ex_operand_stage_forward_mux.sv
// Operand bypass: EX/MEM beats MEM/WB beats register file; r0 never bypassed.
module forward_mux #(parameter int DW = 32, parameter int RW = 5) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_val,
  input  logic          em_wr,
  input  logic [RW-1:0] em_rd,
  input  logic [DW-1:0] em_val,
  input  logic          mw_wr,
  input  logic [RW-1:0] mw_rd,
  input  logic [DW-1:0] mw_val,
  output logic [DW-1:0] opnd
);
  // Priority select among bypass sources
  always_comb begin
    opnd = reg_val;
    if (em_wr && em_rd != '0 && em_rd == src)      opnd = em_val;
    else if (mw_wr && mw_rd != '0 && mw_rd == src) opnd = mw_val;
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: registers decoded fields, decodes AluOP,
// bypasses operands into the ALU and raises load-use stalls.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic Clk,
  input logic Rst_n,
  id_ex_operand_stage_if.slave bus
);
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [RW-1:0] ex_rs, ex_rt, ex_wr;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, fwd_rs, fwd_rt;
  logic [2:0]    ex_op;
  logic [4:0]    ex_sh;
  logic [3:0]    ex_ctrl;
  logic          ex_alusrc;
  logic [1:0]    vld_pipe;   // [0] = ID valid, [1] = EX valid
  logic          stall;

  assign id_rs = bus.IdRegs[3*RW-1:2*RW];
  assign id_rt = bus.IdRegs[2*RW-1:RW];
  assign id_rd = bus.IdRegs[RW-1:0];
  assign vld_pipe[0] = bus.IdValid;

  // Load in EX whose destination the ID instruction reads; muted during Hold
  assign stall = vld_pipe[1] && ex_ctrl[X_MEMREAD] && ex_wr != '0 &&
                 (ex_wr == id_rs || (bus.IdUsesRt && ex_wr == id_rt)) &&
                 vld_pipe[0] && !bus.Hold;

  // Pipeline register: flush > hold > stall bubble > load
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_pipe[1] <= 1'b0;
      ex_ctrl     <= '0;
      ex_alusrc   <= 1'b0;
      ex_op       <= ALU_AND;
      ex_sh       <= '0;
      ex_wr       <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
    end else if (bus.Flush || (!bus.Hold && stall)) begin
      vld_pipe[1] <= 1'b0;
      ex_ctrl     <= '0;
      ex_alusrc   <= 1'b0;
    end else if (!bus.Hold) begin
      vld_pipe[1] <= vld_pipe[0];
      ex_ctrl     <= vld_pipe[0] ? bus.IdCtrl[3:0] : 4'b0;
      ex_alusrc   <= vld_pipe[0] & bus.IdCtrl[C_ALUSRC];
      ex_op       <= alu_decode(bus.IdAluOpMain, bus.IdInstrLow[5:0]);
      ex_sh       <= bus.IdInstrLow[10:6];
      ex_wr       <= bus.IdCtrl[C_REGDST] ? id_rd : id_rt;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rs_data  <= bus.IdRsData;
      ex_rt_data  <= bus.IdRtData;
      ex_imm      <= bus.IdImm;
    end
  end

  forward_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src(ex_rs), .reg_val(ex_rs_data),
    .em_wr(bus.ExMemRegWrite), .em_rd(bus.ExMemRd), .em_val(bus.ExMemResult),
    .mw_wr(bus.MemWbRegWrite), .mw_rd(bus.MemWbRd), .mw_val(bus.MemWbData),
    .opnd(fwd_rs)
  );

  forward_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src(ex_rt), .reg_val(ex_rt_data),
    .em_wr(bus.ExMemRegWrite), .em_rd(bus.ExMemRd), .em_val(bus.ExMemResult),
    .mw_wr(bus.MemWbRegWrite), .mw_rd(bus.MemWbRd), .mw_val(bus.MemWbData),
    .opnd(fwd_rt)
  );

  assign bus.AluInput1   = fwd_rs;
  assign bus.AluInput2   = ex_alusrc ? ex_imm : fwd_rt;
  assign bus.ExStoreData = fwd_rt;
  assign bus.AluOP       = ex_op;
  assign bus.ShiftAmount = ex_sh;
  assign bus.ExValid     = vld_pipe[1];
  assign bus.ExWriteReg  = ex_wr;
  assign bus.ExCtrl      = ex_ctrl;
  assign bus.HazardStall = stall;
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-delivery stage of the 5-stage MIPS pipeline.
- Sits directly upstream of the ALU and drives its Input1, Input2, AluOP and ShiftAmount.
- Registers decoded ID-stage fields and decodes AluOP from opcode class and funct.
- Resolves EX/MEM and MEM/WB forwarding, and detects load-use hazards, inserting a bubble when one occurs.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- Clk  in  1  clock; rising-edge.
- Rst_n  in  1  asynchronous active-low reset.
- IdValid  in  1  ID stage holds a real instruction.
- IdRegs  in  3*RW  {rs, rt, rd} indices.
- IdRsData  in  DW  register-file rs value.
- IdRtData  in  DW  register-file rt value.
- IdImm  in  DW  sign/zero-extended immediate.
- IdInstrLow  in  11  instr[10:0] = {shamt, funct}.
- IdAluOpMain  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type, 11 or (ori).
- IdCtrl  in  6  {RegDst, AluSrc, RegWrite, MemRead, MemWrite, MemToReg}.
- IdUsesRt  in  1  ID instruction reads rt as a source.
- Hold  in  1  downstream freeze; register keeps its contents.
- Flush  in  1  branch/exception kill of the ID instruction.
- ExMemRegWrite  in  1  EX/MEM instruction writes a register.
- ExMemRd  in  RW  EX/MEM destination.
- ExMemResult  in  DW  EX/MEM ALU result.
- MemWbRegWrite  in  1  MEM/WB instruction writes a register.
- MemWbRd  in  RW  MEM/WB destination.
- MemWbData  in  DW  MEM/WB writeback value.
- AluInput1  out  DW  forwarded rs operand.
- AluInput2  out  DW  forwarded rt operand, or immediate when AluSrc=1.
- AluOP  out  3  ALU operation code.
- ShiftAmount  out  5  registered shamt.
- ExValid  out  1  EX stage holds a real instruction.
- ExWriteReg  out  RW  destination: rd if RegDst=1, else rt.
- ExCtrl  out  4  {RegWrite, MemRead, MemWrite, MemToReg}; all zero when ExValid=0.
- ExStoreData  out  DW  forwarded rt value for sw.
- HazardStall  out  1  load-use stall request to IF/ID; combinational.

Behaviour:
- Reset (Rst_n=0, asynchronous): every register clears; ExValid=0, ExCtrl=0, AluOP=3'b000, ShiftAmount=0, ExWriteReg=0.
- Latency: one cycle from ID inputs to the registered EX fields.
- Forwarding and the AluSrc mux are combinational on registered state.
- Register update priority per rising edge:
  1. Flush=1: load a bubble (ExValid=0, all control cleared). Flush wins even while Hold=1.
  2. Hold=1: keep all contents.
  3. HazardStall=1: load a bubble.
  4. Otherwise load the ID fields. ExValid=IdValid; control is zeroed when IdValid=0.
- HazardStall = ExValid & MemRead(reg) & ExWriteReg!=0 & (ExWriteReg==rs(ID) | (IdUsesRt & ExWriteReg==rt(ID))) & IdValid.
  - Asserted for exactly one cycle per load-use pair unless Hold is also asserted.
  - Forced to 0 while Hold=1.
- AluOP decode, registered at load time:
  - IdAluOpMain: 00→010, 01→110, 11→001, 10→funct decode.
  - funct: 100000/100001→010, 100010/100011→110, 100100→000, 100101→001, 101010→111, 000000→011.
  - Any other funct→010.
- Forwarding, per source (rs for Input1; rt for Input2/ExStoreData):
  - Use ExMemResult if ExMemRegWrite & ExMemRd!=0 & ExMemRd==src.
  - Else use MemWbData if MemWbRegWrite & MemWbRd!=0 & MemWbRd==src.
  - Else use the registered file value.
  - EX/MEM has priority over MEM/WB; register 0 is never forwarded.
- AluInput2 = AluSrc ? registered IdImm : forwarded rt.
- ExStoreData always carries forwarded rt, regardless of AluSrc.
- Bubble outputs: AluInput1/2 may carry stale data, but ExCtrl must be 0 and ExValid 0.

Decomposition:
- Shared package mips_pkg:
  - AluOP codes: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SLL=011, ALU_SUB=110, ALU_SLT=111.
  - IdAluOpMain encodings.
  - funct constants.
  - IdCtrl/ExCtrl bit positions.
- One sub-module: forward_mux, instantiated twice. Inputs: src index, register value, both forward buses. Output: selected operand.

Test Plan:
- Reset then idle: Rst_n low mid-cycle → all outputs 0 immediately, HazardStall=0.
- R-type add, rs=3/rt=4 with data 5/7, funct 100000 → next cycle AluOP=010, AluInput1=5, AluInput2=7, ExWriteReg=rd.
- Double forward: ExMemRd=3 (0x11) and MemWbRd=3 (0x22) both writing → AluInput1=0x11. Set ExMemRegWrite=0 → 0x22. Set ExMemRd=0, MemWbRd=0 → file value.
- Load-use: lw to r8 in EX, ID add reads rt=8 with IdUsesRt=1 → HazardStall=1 for one cycle, bubble loaded (ExValid=0, ExCtrl=0). Next cycle the add loads, HazardStall=0.
- Flush with Hold both high on a valid sw → ExValid=0 next cycle. Hold alone → all outputs unchanged for 3 cycles.
- ori with IdAluOpMain=11, AluSrc=1, IdImm=0x0000FFFF → AluOP=001, AluInput2=0x0000FFFF, ExStoreData=forwarded rt.
